// File: rtl/management_bus_fabric_pkg.sv
// Shared types and constants for the management bus fabric.
// Holds the read FSM state encoding, the error-read data value and a saturating increment.
package MgmtFabricPkg;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    localparam logic [7:0] RD_ERR_DATA = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/management_bus_fabric_tracker.sv
// Read tracker: IDLE/WAIT FSM, down-counting response timeout and error counters.
// Define MGMT_FABRIC_RD_PIPELINE_EN to add one register stage on rd_valid/rd_data.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no read outstanding; a new rd_en is accepted
// WAIT  | read issued; waiting for the selected target or the timeout
module MgmtReadTracker
    import MgmtFabricPkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_en,
    input  logic       rd_mapped,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    output logic       accept,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic [7:0] timeout_count,
    output logic [7:0] overlap_count
);

    localparam logic [0:0]  ST_IDLE = RD_IDLE;
    localparam logic [0:0]  ST_WAIT = RD_WAIT;
    localparam logic [15:0] TC_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [0:0]  state;
    logic [15:0] wait_cnt;
    logic        err_valid;
    logic        busy;
    logic        rsp_fire;
    logic        out_valid;
    logic [7:0]  out_data;

    assign busy     = (state == ST_WAIT);
    assign accept   = rd_en && !busy && rd_mapped;
    assign rsp_fire = busy && rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            err_valid     <= 1'b0;
            timeout_count <= '0;
            overlap_count <= '0;
        end else begin
            err_valid <= 1'b0;
            if (rd_en && busy)
                overlap_count <= sat_inc(overlap_count);
            case (state)
                ST_IDLE: begin
                    if (rd_en && rd_mapped) begin
                        state    <= ST_WAIT;
                        wait_cnt <= TC_LOAD;
                    end else if (rd_en) begin
                        err_valid <= 1'b1;
                    end
                end
                default: begin
                    if (rsp_valid) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 16'd0) begin
                        state         <= ST_IDLE;
                        err_valid     <= 1'b1;
                        timeout_count <= sat_inc(timeout_count);
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // A target response and a registered error can never coincide: errors only leave IDLE-side cycles.
    always_comb begin
        out_valid = rst_n && (rsp_fire || err_valid);
        out_data  = 8'h00;
        if (rst_n && rsp_fire)
            out_data = rsp_data;
        else if (rst_n && err_valid)
            out_data = RD_ERR_DATA;
    end

`ifdef MGMT_FABRIC_RD_PIPELINE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            rd_valid <= out_valid;
            rd_data  <= out_data;
        end
    end
`else
    assign rd_valid = out_valid;
    assign rd_data  = out_data;
`endif

endmodule

// File: rtl/management_bus_fabric.sv
// Management bus fabric: decodes host reads/writes onto per-target strobes.
// Define MGMT_FABRIC_RD_PIPELINE_EN to register the read response for one extra cycle.
module management_bus_fabric
    import MgmtFabricPkg::*;
#(
    parameter int NUM_TARGETS      = 4,
    parameter int TARGET_ADDR_BITS = 12,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_en,
    input  logic [15:0]                   rd_addr,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    input  logic                          wr_en,
    input  logic [15:0]                   wr_addr,
    input  logic [7:0]                    wr_data,
    output logic [NUM_TARGETS-1:0]        t_rd_en,
    output logic [NUM_TARGETS-1:0]        t_wr_en,
    output logic [TARGET_ADDR_BITS-1:0]   t_addr,
    output logic [7:0]                    t_wr_data,
    input  logic [NUM_TARGETS-1:0]        t_rd_valid,
    input  logic [8*NUM_TARGETS-1:0]      t_rd_data,
    output logic [7:0]                    timeout_count,
    output logic [7:0]                    overlap_count
);

    localparam int IDX_W = 16 - TARGET_ADDR_BITS;

    logic [IDX_W-1:0]       rd_idx;
    logic [IDX_W-1:0]       wr_idx;
    logic                   rd_mapped;
    logic                   wr_mapped;
    logic                   accept;
    logic [NUM_TARGETS-1:0] sel;
    logic                   rsp_valid;
    logic [7:0]             rsp_data;

    assign rd_idx    = rd_addr[15:TARGET_ADDR_BITS];
    assign wr_idx    = wr_addr[15:TARGET_ADDR_BITS];
    assign rd_mapped = 32'(rd_idx) < NUM_TARGETS;
    assign wr_mapped = 32'(wr_idx) < NUM_TARGETS;

    // t_addr is shared; when a write and a read issue together the write offset wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_rd_en   <= '0;
            t_wr_en   <= '0;
            t_addr    <= '0;
            t_wr_data <= '0;
            sel       <= '0;
        end else begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                t_rd_en[i] <= accept && (32'(rd_idx) == i);
                t_wr_en[i] <= wr_en && wr_mapped && (32'(wr_idx) == i);
                if (accept)
                    sel[i] <= (32'(rd_idx) == i);
            end
            if (wr_en && wr_mapped) begin
                t_addr    <= wr_addr[TARGET_ADDR_BITS-1:0];
                t_wr_data <= wr_data;
            end else if (accept) begin
                t_addr <= rd_addr[TARGET_ADDR_BITS-1:0];
            end
        end
    end

    always_comb begin
        rsp_valid = |(t_rd_valid & sel);
        rsp_data  = 8'h00;
        for (int i = 0; i < NUM_TARGETS; i++)
            if (sel[i])
                rsp_data = rsp_data | t_rd_data[8*i +: 8];
    end

    MgmtReadTracker #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_en        (rd_en),
        .rd_mapped    (rd_mapped),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .accept       (accept),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .timeout_count(timeout_count),
        .overlap_count(overlap_count)
    );

endmodule

// File: tb/tb_management_bus_fabric.sv
// Bench for management_bus_fabric: directed cycle checks plus a read-data scoreboard.
module tb_management_bus_fabric;

    localparam int NT  = 4;
    localparam int TAB = 12;
`ifdef MGMT_FABRIC_RD_PIPELINE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rd_en;
    logic [15:0]     rd_addr;
    logic            rd_valid;
    logic [7:0]      rd_data;
    logic            wr_en;
    logic [15:0]     wr_addr;
    logic [7:0]      wr_data;
    logic [NT-1:0]   t_rd_en;
    logic [NT-1:0]   t_wr_en;
    logic [TAB-1:0]  t_addr;
    logic [7:0]      t_wr_data;
    logic [NT-1:0]   t_rd_valid;
    logic [8*NT-1:0] t_rd_data;
    logic [7:0]      timeout_count;
    logic [7:0]      overlap_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    management_bus_fabric #(
        .NUM_TARGETS(NT),
        .TARGET_ADDR_BITS(TAB),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .t_rd_en(t_rd_en), .t_wr_en(t_wr_en),
        .t_addr(t_addr), .t_wr_data(t_wr_data),
        .t_rd_valid(t_rd_valid), .t_rd_data(t_rd_data),
        .timeout_count(timeout_count), .overlap_count(overlap_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; wr_en = 1'b0; t_rd_valid = '0;
    endtask

    // Every read response is checked against the oldest expected value.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0)
                chk("unexpected_rd_valid", {24'h0, rd_data}, 32'hDEAD);
            else
                chk("rd_data", {24'h0, rd_data}, {24'h0, sb.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; t_rd_data = '0;
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_t_rd_en", 32'(t_rd_en), 0);
        chk("rst_t_wr_en", 32'(t_wr_en), 0);
        chk("rst_t_addr", 32'(t_addr), 0);
        chk("rst_t_wr_data", 32'(t_wr_data), 0);
        chk("rst_timeout_count", 32'(timeout_count), 0);
        chk("rst_overlap_count", 32'(overlap_count), 0);
        tick(); rst_n = 1'b1;

        // Write 0x1234 = 0xA5 lands on target 1 one cycle later.
        tick(); wr_en = 1'b1; wr_addr = 16'h1234; wr_data = 8'hA5;
        tick(); idle_inputs();
        @(negedge clk);
        chk("wr_t_wr_en", 32'(t_wr_en), 32'b0010);
        chk("wr_t_addr", 32'(t_addr), 32'h234);
        chk("wr_t_wr_data", 32'(t_wr_data), 32'hA5);
        tick();
        @(negedge clk);
        chk("wr_strobe_pulse", 32'(t_wr_en), 0);

        // Unmapped write is dropped; stray idle responses are ignored.
        wr_en = 1'b1; wr_addr = 16'h8001; wr_data = 8'h3E;
        t_rd_valid = 4'b1111; t_rd_data = 32'h11223344;
        @(negedge clk);
        chk("idle_rsp_ignored", 32'(rd_valid), 0);
        tick(); idle_inputs();
        @(negedge clk);
        chk("unmapped_wr_dropped", 32'(t_wr_en), 0);

        // Read 0x2010, non-selected target chatters, target 2 answers 0x5A.
        tick(); rd_en = 1'b1; rd_addr = 16'h2010; sb.push_back(8'h5A);
        tick(); idle_inputs();
        @(negedge clk);
        chk("rd_t_rd_en", 32'(t_rd_en), 32'b0100);
        chk("rd_t_addr", 32'(t_addr), 32'h010);
        tick(); t_rd_valid = 4'b0001; t_rd_data = 32'h00000011;
        @(negedge clk);
        chk("nonsel_rsp_ignored", 32'(rd_valid), 0);
        tick(); t_rd_valid = 4'b0100; t_rd_data = 32'h005A0000;
        @(negedge clk);
        chk("rd_rsp_cycle", 32'(rd_valid), 32'(1 - PIPE));
        tick(); idle_inputs();
        @(negedge clk);
        chk("rd_rsp_cycle_next", 32'(rd_valid), 32'(PIPE));

        // Unmapped read 0x7000 answers 0xFF at N+1 with no strobe.
        tick(); rd_en = 1'b1; rd_addr = 16'h7000; sb.push_back(8'hFF);
        tick(); idle_inputs();
        @(negedge clk);
        chk("unmapped_rd_no_strobe", 32'(t_rd_en), 0);
        chk("unmapped_rd_valid", 32'(rd_valid), 32'(1 - PIPE));
        tick(); tick();

        // Target 1 never answers: timeout after 8 wait cycles.
        rd_en = 1'b1; rd_addr = 16'h1000; sb.push_back(8'hFF);
        tick(); idle_inputs();
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rd_valid) begin
                seen = k;
                break;
            end
        end
        chk("timeout_latency", 32'(seen), 32'(9 + PIPE));
        chk("timeout_count", 32'(timeout_count), 1);
        tick(); tick();

        // Overlapping reads are dropped; write during WAIT is forwarded.
        rd_en = 1'b1; rd_addr = 16'h3004; sb.push_back(8'h3C);
        tick(); idle_inputs();
        tick(); rd_en = 1'b1; rd_addr = 16'h0000;
        wr_en = 1'b1; wr_addr = 16'h0055; wr_data = 8'h77;
        tick(); idle_inputs();
        @(negedge clk);
        chk("ovl_no_t_rd_en", 32'(t_rd_en), 0);
        chk("ovl_wr_forwarded", 32'(t_wr_en), 32'b0001);
        chk("ovl_wr_addr", 32'(t_addr), 32'h055);
        chk("ovl_count_1", 32'(overlap_count), 1);
        tick(); t_rd_valid = 4'b1000; t_rd_data = 32'h3C000000;
        rd_en = 1'b1; rd_addr = 16'h3000;
        tick(); idle_inputs();
        @(negedge clk);
        chk("ovl_rsp_cycle_drop", 32'(t_rd_en), 0);
        chk("ovl_count_2", 32'(overlap_count), 2);
        tick(); tick();

        // Simultaneous read and write are both serviced.
        rd_en = 1'b1; rd_addr = 16'h0ABC;
        wr_en = 1'b1; wr_addr = 16'h2DEF; wr_data = 8'h99;
        sb.push_back(8'h42);
        tick(); idle_inputs();
        @(negedge clk);
        chk("sim_t_rd_en", 32'(t_rd_en), 32'b0001);
        chk("sim_t_wr_en", 32'(t_wr_en), 32'b0100);
        chk("sim_t_wr_data", 32'(t_wr_data), 32'h99);
        chk("sim_t_addr", 32'(t_addr), 32'hDEF);
        tick(); t_rd_valid = 4'b0001; t_rd_data = 32'h00000042;
        tick(); idle_inputs();
        tick(); tick();

        // Reset mid-WAIT abandons the read; late response is ignored.
        rd_en = 1'b1; rd_addr = 16'h2000;
        tick(); idle_inputs();
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; t_rd_valid = 4'b0100; t_rd_data = 32'h00660000;
        @(negedge clk);
        chk("late_rsp_ignored_0", 32'(rd_valid), 0);
        tick();
        @(negedge clk);
        chk("late_rsp_ignored_1", 32'(rd_valid), 0);
        chk("post_rst_timeout_count", 32'(timeout_count), 0);
        chk("post_rst_overlap_count", 32'(overlap_count), 0);
        tick(); idle_inputs();

        // Fabric is usable again after reset.
        rd_en = 1'b1; rd_addr = 16'h1001; sb.push_back(8'hC3);
        tick(); idle_inputs();
        tick(); t_rd_valid = 4'b0010; t_rd_data = 32'h0000C300;
        tick(); idle_inputs();
        repeat (4) tick();
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
